// File: rtl/alu_cmd_driver.sv
// Initiator for the packed-pin ALU: packs commands into alu_in, waits a settle time, returns alu_out.
// Defining ALU_CMD_CHECK_EN adds a golden-model checker with rsp_mismatch and err_sticky outputs.
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_a,
  input  logic [1:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_shamt,
  output logic [7:0]       alu_in,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_CMD_CHECK_EN
  ,
  output logic             rsp_mismatch,
  output logic             err_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       alu_in_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_valid_q;
  logic [CNT_W-1:0] op_count_q;
  logic [7:0]       pack_d;
  logic             rsp_hs_d;

  assign pack_d    = {cmd_shamt, cmd_op, cmd_b, cmd_a};
  assign rsp_hs_d  = rsp_valid_q & rsp_ready;
  // A response handshake frees the block in the same cycle, so a new command needs no IDLE bubble.
  assign cmd_ready = ~rst & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_in_q    <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_in_q <= pack_d;
            cnt_q    <= SETTLE_INIT;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= alu_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_hs_d) begin
            op_count_q  <= op_count_q + CNT_W'(1);
            rsp_valid_q <= 1'b0;
            if (cmd_valid) begin
              alu_in_q <= pack_d;
              cnt_q    <= SETTLE_INIT;
              state_q  <= SETTLE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_in    = alu_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

`ifdef ALU_CMD_CHECK_EN
  // Reference ALU: 8-bit zero-extended operands, odd opcodes subtract.
  function automatic logic [7:0] golden(input logic [7:0] in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [2:0] op;
    logic       sub;
    logic [8:0] s;
    a   = {6'b0, in[1:0]};
    b   = {6'b0, in[3:2]};
    op  = in[6:4];
    sub = op[0];
    s   = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {8'b0, sub};
    case (op)
      3'b000, 3'b001: r = s[7:0];
      3'b010:         r = a & b;
      3'b011:         r = a | b;
      3'b100, 3'b101: r = s[7:0] << in[7];
      default:        r = s[7:0] >> in[7];
    endcase
    return {1'b0, r[7], (r == 8'd0), s[8] & (op != 3'b010), r[3:0]};
  endfunction

  logic mismatch_q;
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if ((state_q == SETTLE) && (cnt_q == 4'd0)) begin
        mismatch_q <= (golden(alu_in_q) != alu_out);
      end
      if (rsp_hs_d && mismatch_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_mismatch = rsp_valid_q & mismatch_q;
  assign err_sticky   = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed scoreboard bench for alu_cmd_driver; the bench also plays the ALU on alu_in/alu_out.
module tb_alu_cmd_driver;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_a = 2'd0;
  logic [1:0] cmd_b = 2'd0;
  logic [2:0] cmd_op = 3'd0;
  logic       cmd_shamt = 1'b0;
  logic [7:0] alu_in;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] op_count;
`ifdef ALU_CMD_CHECK_EN
  logic       rsp_mismatch;
  logic       err_sticky;
`endif

  logic       forceBad = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] lastExp = 8'h00;
  logic [7:0] expCount = 8'h00;
  int         totalOps = 0;
  int         compared = 0;
  int         mismatched = 0;

  alu_cmd_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_shamt(cmd_shamt),
    .alu_in(alu_in), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
`ifdef ALU_CMD_CHECK_EN
    , .rsp_mismatch(rsp_mismatch), .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] aluModel(input logic [1:0] a, input logic [1:0] b,
                                          input logic [2:0] op, input logic sh);
    logic [8:0] sum;
    logic [7:0] res;
    logic       isSub;
    logic       cy;
    isSub = (op == 3'b001) || (op == 3'b011) || (op == 3'b101) || (op == 3'b111);
    if (isSub) sum = {7'b0, a} + {1'b0, 8'hFF ^ {6'b0, b}} + 9'd1;
    else       sum = {7'b0, a} + {7'b0, b};
    cy = sum[8] && (op != 3'b010);
    if (op == 3'b010)           res = {6'b0, a & b};
    else if (op == 3'b011)      res = {6'b0, a | b};
    else if (op[2:1] == 2'b00)  res = sum[7:0];
    else if (op[2:1] == 2'b10)  res = sh ? {sum[6:0], 1'b0} : sum[7:0];
    else                        res = sh ? {1'b0, sum[7:1]} : sum[7:0];
    return {1'b0, res[7], (res == 8'h00), cy, res[3:0]};
  endfunction

  always_comb begin
    alu_out = forceBad ? 8'h20 : aluModel(alu_in[1:0], alu_in[3:2], alu_in[6:4], alu_in[7]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                               input logic sh, input logic [7:0] expPack);
    int n;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_shamt = sh;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("cmdReadyTimeout", {31'b0, cmd_ready}, 32'd1);
    expQ.push_back(forceBad ? 8'h20 : aluModel(a, b, op, sh));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = ~a; cmd_b = ~b; cmd_op = ~op; cmd_shamt = ~sh;
    checkOutput("aluInPack", {24'b0, alu_in}, {24'b0, expPack});
  endtask

  task automatic waitResponse(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 40);
    checkOutput({tag, "_latency"}, lat, SETTLE);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_scoreboardEmpty"}, 32'(expQ.size()), 32'd1);
    end else begin
      lastExp = expQ.pop_front();
      checkOutput({tag, "_rspData"}, {24'b0, rsp_data}, {24'b0, lastExp});
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    expCount = expCount + 8'd1;
    totalOps++;
    checkOutput("opCount", {24'b0, op_count}, {24'b0, expCount});
  endtask

  initial begin
    logic sawValid;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] rop;
    logic rsh;

    #2;
    checkOutput("rstRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstAluIn", {24'b0, alu_in}, 32'h00);
    checkOutput("rstRspData", {24'b0, rsp_data}, 32'h00);
    checkOutput("rstOpCount", {24'b0, op_count}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstCmdReady", {31'b0, cmd_ready}, 32'd1);

    applyStimulus(2'd3, 2'd2, 3'b000, 1'b0, 8'h0B);
    checkOutput("addBusy", {31'b0, busy}, 32'd1);
    waitResponse("add");
    checkOutput("addRspConst", {24'b0, rsp_data}, 32'h05);
    handshake();

    applyStimulus(2'd1, 2'd2, 3'b001, 1'b0, 8'h19);
    waitResponse("sub");
    checkOutput("subRspConst", {24'b0, rsp_data}, 32'h4F);
    handshake();

    forceBad = 1'b1;
    applyStimulus(2'd2, 2'd2, 3'b001, 1'b0, 8'h1A);
    waitResponse("subEqBad");
`ifdef ALU_CMD_CHECK_EN
    checkOutput("rspMismatchSet", {31'b0, rsp_mismatch}, 32'd1);
`endif
    handshake();
    forceBad = 1'b0;
    applyStimulus(2'd2, 2'd2, 3'b001, 1'b0, 8'h1A);
    waitResponse("subEq");
    checkOutput("subEqRspConst", {24'b0, rsp_data}, 32'h30);
`ifdef ALU_CMD_CHECK_EN
    checkOutput("rspMismatchClear", {31'b0, rsp_mismatch}, 32'd0);
`endif
    handshake();
`ifdef ALU_CMD_CHECK_EN
    checkOutput("errSticky", {31'b0, err_sticky}, 32'd1);
`endif

    applyStimulus(2'd0, 2'd1, 3'b111, 1'b1, 8'hF4);
    waitResponse("subShr");
    checkOutput("subShrRspConst", {24'b0, rsp_data}, 32'h0F);
    handshake();

    // Backpressure, then a command riding on the response handshake.
    applyStimulus(2'd1, 2'd1, 3'b000, 1'b0, 8'h05);
    waitResponse("bp");
    @(negedge clk);
    cmd_a = 2'd3; cmd_b = 2'd3; cmd_op = 3'b011; cmd_shamt = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpRspStable", {24'b0, rsp_data}, {24'b0, lastExp});
      checkOutput("bpCmdReadyLow", {31'b0, cmd_ready}, 32'd0);
      checkOutput("bpRspValid", {31'b0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("b2bCmdReady", {31'b0, cmd_ready}, 32'd1);
    expQ.push_back(aluModel(2'd3, 2'd3, 3'b011, 1'b0));
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    expCount = expCount + 8'd1;
    totalOps++;
    checkOutput("b2bOpCount", {24'b0, op_count}, {24'b0, expCount});
    checkOutput("b2bAluIn", {24'b0, alu_in}, 32'h3F);
    checkOutput("b2bRspValidLow", {31'b0, rsp_valid}, 32'd0);
    checkOutput("b2bNoBubble", {31'b0, busy}, 32'd1);
    waitResponse("b2b");
    checkOutput("b2bRspConst", {24'b0, rsp_data}, 32'h13);
    handshake();

    // Reset one edge after accept discards the operation.
    applyStimulus(2'd2, 2'd1, 3'b000, 1'b0, 8'h06);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midRstAluIn", {24'b0, alu_in}, 32'h00);
    checkOutput("midRstOpCount", {24'b0, op_count}, 32'd0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    expQ.delete();
    expCount = 8'h00;
    totalOps = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawValid = sawValid | rsp_valid;
    end
    checkOutput("midRstNoRsp", {31'b0, sawValid}, 32'd0);
    checkOutput("midRstCmdReady", {31'b0, cmd_ready}, 32'd1);
    checkOutput("idleRspReadyNoEffect", {24'b0, op_count}, 32'd0);
    rsp_ready = 1'b0;

    // Random operations until the 8-bit counter wraps.
    while (totalOps < 256) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      rop = 3'($urandom_range(0, 7));
      rsh = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rop, rsh, {rsh, rop, rb, ra});
      waitResponse("rand");
      handshake();
    end
    checkOutput("opCountWrap", {24'b0, op_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the packed-pin ALU interface. It accepts ALU commands over a valid/ready stream and packs them into the 8-bit ALU input byte (A, B, op, shift bit). It waits a programmable settle time, captures the 8-bit ALU output byte (result nibble plus flags) and returns it on a valid/ready response stream. It sits between a host/test controller and the ALU pin interface, and is the block that drives and reads that interface.

Parameters:
SETTLE_CYCLES, 2, clock edges between driving alu_in and sampling alu_out; legal range 1..15.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept command
cmd_a  input  2  operand A
cmd_b  input  2  operand B
cmd_op  input  3  ALU control code
cmd_shamt  input  1  shift amount bit
alu_in  output  8  packed byte to ALU: {shamt, op[2:0], b[1:0], a[1:0]}
alu_out  input  8  byte from ALU: [3:0] result nibble, [4] carry, [5] zero, [6] negative, [7] overflow
rsp_valid  output  1  response held
rsp_ready  input  1  consumer takes response
rsp_data  output  8  captured alu_out byte, same bit layout
busy  output  1  high in every state except IDLE
op_count  output  CNT_W  completed responses (handshakes)

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, alu_in=0x00, rsp_valid=0, rsp_data=0x00, op_count=0, settle counter=0; cmd_ready=1 once rst is low.
- States: IDLE, SETTLE, RESP.
- IDLE: cmd_ready=1. On cmd_valid at edge E0: alu_in <= packed byte, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: cmd_ready=0. Counter decrements each edge. At the edge where it reads 0 (edge E0+SETTLE_CYCLES), rsp_data <= alu_out, rsp_valid <= 1, go to RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge. For the default value, that is 2.
- RESP: rsp_valid=1 and rsp_data are stable until rsp_valid&rsp_ready. On that handshake, op_count increments, wrapping from all-ones to 0.
- Back-to-back: cmd_ready = (state==IDLE) | (state==RESP & rsp_ready).
  - If a command arrives in the same cycle as the response handshake, it is accepted: alu_in is reloaded, the state goes directly to SETTLE, and rsp_valid falls.
  - Otherwise the handshake returns the block to IDLE.
- alu_in holds its last driven value in IDLE and RESP. It never returns to 0 except on reset.
- cmd_* fields are sampled only on the accept edge. Later changes are ignored.
- rsp_ready while rsp_valid=0 has no effect.
- Reset asserted mid-operation (SETTLE or RESP): the operation is discarded, all outputs take their reset values immediately, and no response is produced.
- Fields are passed through bit-exact; the block performs no arithmetic on the datapath.

Optional Feature:
Macro ALU_CMD_CHECK_EN.
- Defined: adds a golden model plus outputs rsp_mismatch (1 bit) and err_sticky (1 bit).
- Golden model:
  - Operands are zero-extended to 8 bits.
  - Ops with odd codes and 101/111 subtract; the others add: S = A + (sub ? ~B : B) + sub.
  - 000/001 give R=S; 010 gives A&B; 011 gives A|B; 100/101 give S<<shamt; 110/111 give S>>shamt.
  - Flags: carry = cout & (op!=010); zero = (R==0); negative = R[7]; overflow = 0.
- rsp_mismatch is valid with rsp_valid: it is 1 when the expected byte differs from the captured byte.
- err_sticky sets on any mismatching response handshake and clears only on rst.
- Not defined: neither port exists, no checker logic, behaviour otherwise identical.

Test Plan:
- Add, 3+2: cmd a=3, b=2, op=000, shamt=0 -> alu_in=0x0B the cycle after accept. ALU model returns 0x05, so rsp_data=0x05, rsp_valid exactly 2 edges after accept, op_count=1.
- Sub, 1-2: a=1, b=2, op=001 -> alu_in=0x19. rsp_data=0x4F (nibble F, negative=1, carry=0).
- Sub equal, 2-2: op=001 -> alu_in=0x1A, rsp_data=0x30 (carry=1, zero=1). With ALU_CMD_CHECK_EN and an alu_out forced to 0x20: rsp_mismatch=1, err_sticky stays 1 after the next good response.
- Sub then shift right, 0-1 >>1: a=0, b=1, op=111, shamt=1 -> alu_in=0xF4, rsp_data=0x0F.
- Back-to-back with backpressure: hold rsp_ready=0 for 5 cycles -> rsp_data stable, cmd_ready=0. Raise rsp_ready together with cmd_valid -> the new command is accepted that edge with no IDLE bubble. 256 handshakes with CNT_W=8 -> op_count wraps to 0.
- Reset mid-SETTLE: assert rst one edge after accept -> rsp_valid=0, alu_in=0x00, op_count=0 immediately. No response after release, and cmd_ready=1.
